// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester handshakes (fetch, data) and the memory bus
// around mem_arbiter. The arbiter connects through the slave modport; the
// requesters and the memory model connect through the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  // instruction-fetch requester
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_done;
  logic [DATA_WIDTH-1:0] if_rdata;

  // data load/store requester
  logic                  dt_req;
  logic                  dt_we;
  logic [ADDR_WIDTH-1:0] dt_addr;
  logic [DATA_WIDTH-1:0] dt_wdata;
  logic                  dt_gnt;
  logic                  dt_done;
  logic [DATA_WIDTH-1:0] dt_rdata;

  // single-port memory
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_done, if_rdata,
    input  dt_req, dt_we, dt_addr, dt_wdata,
    output dt_gnt, dt_done, dt_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_done, if_rdata,
    output dt_req, dt_we, dt_addr, dt_wdata,
    input  dt_gnt, dt_done, dt_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// One access at a time: IDLE picks a winner (round-robin on ties), ACCESS
// holds mem_en for WAIT_CYCLES cycles, DONE pulses the owner's done.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  // WAIT_CYCLES is at most 15, so the counter never exceeds 14
  localparam int              CW   = 4;
  localparam logic [CW-1:0]   LAST = CW'(WAIT_CYCLES - 1);

  state_t                state;
  state_t                state_nxt;
  owner_t                owner;
  owner_t                last_owner;
  logic [CW-1:0]         cnt;
  logic                  cnt_last;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dt_rdata_q;

  logic                  pick_fetch;
  logic                  pick_data;

  assign cnt_last = (cnt == LAST);

  // Arbitration: a lone request wins; on a tie the requester that did not
  // win last time goes first, so a pending loser beats a repeat request.
  always_comb begin
    pick_fetch = bus.if_req && (!bus.dt_req || (last_owner == OWN_DATA));
    pick_data  = bus.dt_req && !pick_fetch;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (bus.if_req || bus.dt_req) state_nxt = S_ACCESS;
      S_ACCESS: if (cnt_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the winner's request, count wait cycles, capture reads
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      owner      <= OWN_FETCH;
      last_owner <= OWN_DATA;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dt_rdata_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (pick_fetch) begin
            owner   <= OWN_FETCH;
            addr_q  <= bus.if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
          end else if (pick_data) begin
            owner   <= OWN_DATA;
            addr_q  <= bus.dt_addr;
            we_q    <= bus.dt_we;
            wdata_q <= bus.dt_wdata;
          end
        end
        S_ACCESS: begin
          if (cnt_last) begin
            cnt        <= '0;
            last_owner <= owner;
            if (!we_q) begin
              if (owner == OWN_FETCH) begin
                if_rdata_q <= bus.mem_rdata;
              end else begin
                dt_rdata_q <= bus.mem_rdata;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from state and owner; address/data come from registers
  always_comb begin
    bus.if_gnt    = (state == S_ACCESS) && (owner == OWN_FETCH);
    bus.dt_gnt    = (state == S_ACCESS) && (owner == OWN_DATA);
    bus.if_done   = (state == S_DONE)   && (owner == OWN_FETCH);
    bus.dt_done   = (state == S_DONE)   && (owner == OWN_DATA);
    bus.mem_en    = (state == S_ACCESS);
    bus.mem_we    = (state == S_ACCESS) && we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.if_rdata  = if_rdata_q;
    bus.dt_rdata  = dt_rdata_q;
    bus.busy      = (state != S_IDLE);
  end

  // Ownership is exclusive: never two grants or two done pulses at once
  gnt_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(bus.if_gnt && bus.dt_gnt));
  done_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(bus.if_done && bus.dt_done));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=2 and one with
// WAIT_CYCLES=1. Expected completions are queued when a request is raised and
// compared when a done pulse appears.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct packed {
    logic          is_fetch;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) c ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (b.slave)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (c.slave)
  );

  // read-only memory model, combinational read
  logic [DW-1:0] mem [256];
  assign b.mem_rdata = mem[b.mem_addr];
  assign c.mem_rdata = mem[c.mem_addr];

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step until a done pulse on instance u1 (0: WAIT=2, 1: WAIT=1), then
  // compare it against the scoreboard head. cycles = ticks taken.
  task automatic wait_done(input bit u1, input int budget, output int cycles);
    logic ifd, dtd, ifg, dtg;
    logic [DW-1:0] ir, dr;
    exp_t e;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cycles++;
      ifd = u1 ? c.if_done  : b.if_done;
      dtd = u1 ? c.dt_done  : b.dt_done;
      ifg = u1 ? c.if_gnt   : b.if_gnt;
      dtg = u1 ? c.dt_gnt   : b.dt_gnt;
      ir  = u1 ? c.if_rdata : b.if_rdata;
      dr  = u1 ? c.dt_rdata : b.dt_rdata;
      check("gnt_excl", {31'd0, ifg & dtg}, 32'd0);
      check("done_excl", {31'd0, ifd & dtd}, 32'd0);
      if (ifd || dtd) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL sb_underflow: observed done pulse expected none");
          return;
        end
        e = sb.pop_front();
        check("done_who", {31'd0, ifd}, {31'd0, e.is_fetch});
        check(ifd ? "if_rdata" : "dt_rdata", {24'd0, ifd ? ir : dr}, {24'd0, e.rdata});
        return;
      end
    end
    n_tests++;
    n_fail++;
    $error("FAIL done_timeout: observed no done expected one within %0d cycles", budget);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    {b.if_req, b.if_addr, b.dt_req, b.dt_we, b.dt_addr, b.dt_wdata} = '0;
    {c.if_req, c.if_addr, c.dt_req, c.dt_we, c.dt_addr, c.dt_wdata} = '0;

    // reset state
    reset = 1'b1;
    repeat (2) tick();
    check("rst_busy",     {31'd0, b.busy},     32'd0);
    check("rst_mem_en",   {31'd0, b.mem_en},   32'd0);
    check("rst_mem_addr", {24'd0, b.mem_addr}, 32'd0);
    check("rst_if_rdata", {24'd0, b.if_rdata}, 32'd0);
    check("rst_dt_rdata", {24'd0, b.dt_rdata}, 32'd0);
    check("rst_busy1",    {31'd0, c.busy},     32'd0);
    reset = 1'b0;
    tick();

    // single fetch, WAIT=2: grant t+1..t+2, done t+3
    mem[8'h10] = 8'hA5;
    b.if_addr = 8'h10;
    b.if_req  = 1'b1;
    sb.push_back('{is_fetch: 1'b1, rdata: 8'hA5});
    for (int k = 0; k < 2; k++) begin
      tick();
      check("f1_if_gnt",   {31'd0, b.if_gnt},   32'd1);
      check("f1_dt_gnt",   {31'd0, b.dt_gnt},   32'd0);
      check("f1_mem_en",   {31'd0, b.mem_en},   32'd1);
      check("f1_mem_we",   {31'd0, b.mem_we},   32'd0);
      check("f1_mem_addr", {24'd0, b.mem_addr}, 32'h10);
      check("f1_busy",     {31'd0, b.busy},     32'd1);
    end
    wait_done(0, 4, cyc);
    check("f1_done_lat", cyc, 32'd1);
    check("f1_done_en",  {31'd0, b.mem_en}, 32'd0);
    check("f1_done_gnt", {31'd0, b.if_gnt}, 32'd0);
    b.if_req = 1'b0;
    tick();
    check("f1_idle_busy", {31'd0, b.busy},     32'd0);
    check("f1_idle_done", {31'd0, b.if_done},  32'd0);
    check("f1_hold",      {24'd0, b.if_rdata}, 32'hA5);

    // store: mem_we/mem_wdata for both wait cycles, dt_rdata untouched
    b.dt_addr  = 8'h20;
    b.dt_wdata = 8'h3C;
    b.dt_we    = 1'b1;
    b.dt_req   = 1'b1;
    sb.push_back('{is_fetch: 1'b0, rdata: 8'h00});
    for (int k = 0; k < 2; k++) begin
      tick();
      check("st_dt_gnt",    {31'd0, b.dt_gnt},    32'd1);
      check("st_if_gnt",    {31'd0, b.if_gnt},    32'd0);
      check("st_mem_we",    {31'd0, b.mem_we},    32'd1);
      check("st_mem_wdata", {24'd0, b.mem_wdata}, 32'h3C);
      check("st_mem_addr",  {24'd0, b.mem_addr},  32'h20);
    end
    wait_done(0, 4, cyc);
    check("st_done_we",  {31'd0, b.mem_we},   32'd0);
    check("st_if_keep",  {24'd0, b.if_rdata}, 32'hA5);
    b.dt_req = 1'b0;
    b.dt_we  = 1'b0;
    tick();

    // data load
    mem[8'h21] = 8'h4D;
    b.dt_addr = 8'h21;
    b.dt_req  = 1'b1;
    sb.push_back('{is_fetch: 1'b0, rdata: 8'h4D});
    wait_done(0, 6, cyc);
    check("ld_lat", cyc, 32'd3);
    b.dt_req = 1'b0;
    tick();
    check("ld_if_keep", {24'd0, b.if_rdata}, 32'hA5);

    // simultaneous requests from reset: fetch, data, fetch, data
    mem[8'h30] = 8'h5A;
    mem[8'h40] = 8'hC3;
    reset     = 1'b1;
    b.if_addr = 8'h30;
    b.if_req  = 1'b1;
    b.dt_addr = 8'h40;
    b.dt_we   = 1'b0;
    b.dt_req  = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{is_fetch: 1'b1, rdata: 8'h5A});
      sb.push_back('{is_fetch: 1'b0, rdata: 8'hC3});
    end
    for (int k = 0; k < 4; k++) begin
      wait_done(0, 8, cyc);
      check("rr_period", cyc, (k == 0) ? 32'd3 : 32'd4);
    end
    b.if_req = 1'b0;
    b.dt_req = 1'b0;
    tick();
    check("rr_idle", {31'd0, b.busy}, 32'd0);

    // reset during first ACCESS cycle abandons the access
    b.if_addr = 8'h50;
    b.if_req  = 1'b1;
    tick();
    check("ab_mem_en", {31'd0, b.mem_en}, 32'd1);
    reset = 1'b1;
    tick();
    check("ab_mem_en0",   {31'd0, b.mem_en},   32'd0);
    check("ab_busy",      {31'd0, b.busy},     32'd0);
    check("ab_if_gnt",    {31'd0, b.if_gnt},   32'd0);
    check("ab_mem_addr",  {24'd0, b.mem_addr}, 32'd0);
    check("ab_if_rdata",  {24'd0, b.if_rdata}, 32'd0);
    check("ab_dt_rdata",  {24'd0, b.dt_rdata}, 32'd0);
    reset    = 1'b0;
    b.if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ab_no_done", {31'd0, b.if_done}, 32'd0);
      check("ab_idle",    {31'd0, b.busy},    32'd0);
    end
    mem[8'h52] = 8'h77;
    b.if_addr = 8'h52;
    b.if_req  = 1'b1;
    sb.push_back('{is_fetch: 1'b1, rdata: 8'h77});
    wait_done(0, 6, cyc);
    check("ab_after_lat", cyc, 32'd3);
    b.if_req = 1'b0;
    tick();

    // fetch request dropped in first ACCESS cycle still completes
    mem[8'h60] = 8'h99;
    b.if_addr = 8'h60;
    b.if_req  = 1'b1;
    sb.push_back('{is_fetch: 1'b1, rdata: 8'h99});
    tick();
    check("dr_if_gnt", {31'd0, b.if_gnt}, 32'd1);
    b.if_req = 1'b0;
    wait_done(0, 5, cyc);
    check("dr_lat", cyc, 32'd2);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("dr_busy",    {31'd0, b.busy},    32'd0);
      check("dr_no_done", {31'd0, b.if_done}, 32'd0);
    end

    // WAIT=1: back-to-back fetches 3 cycles apart, then a store
    mem[8'h70] = 8'h11;
    mem[8'h71] = 8'h22;
    c.if_addr = 8'h70;
    c.if_req  = 1'b1;
    sb.push_back('{is_fetch: 1'b1, rdata: 8'h11});
    wait_done(1, 4, cyc);
    check("bb_first_lat", cyc, 32'd2);
    c.if_addr = 8'h71;
    sb.push_back('{is_fetch: 1'b1, rdata: 8'h22});
    wait_done(1, 5, cyc);
    check("bb_period", cyc, 32'd3);
    c.if_req = 1'b0;
    tick();
    c.dt_addr  = 8'h72;
    c.dt_wdata = 8'h5E;
    c.dt_we    = 1'b1;
    c.dt_req   = 1'b1;
    sb.push_back('{is_fetch: 1'b0, rdata: 8'h00});
    tick();
    check("bb_st_we",    {31'd0, c.mem_we},    32'd1);
    check("bb_st_wdata", {24'd0, c.mem_wdata}, 32'h5E);
    wait_done(1, 4, cyc);
    check("bb_if_keep", {24'd0, c.if_rdata}, 32'h22);
    c.dt_req = 1'b0;
    c.dt_we  = 1'b0;
    tick();
    check("bb_idle", {31'd0, c.busy}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
